// File: rtl/version_pkg.sv
// Shared constants, helpers and slot record for the versioned write buffer.
package version_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_VERSION_WIDTH = 4;
  localparam int DEFAULT_VERSION_NUM   = 4;

  function automatic int slotIdxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrapNext(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0]    data;
    logic [DEFAULT_VERSION_WIDTH-1:0] version;
    logic                             valid;
  } slotRec_t;

endpackage

// File: rtl/version_store_wrap_counter.sv
// Modulo-MODULUS counter; inc and incExtra each add one, so both together step by two.
module wrap_counter
  import version_pkg::*;
#(
  parameter int MODULUS = 4,
  parameter int WIDTH   = slotIdxWidth(MODULUS)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inc,
  input  logic             incExtra,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] stepOne;
  logic [WIDTH-1:0] stepTwo;

  always_comb begin
    stepOne = WIDTH'(wrapNext(int'(value), MODULUS));
    stepTwo = WIDTH'(wrapNext(int'(stepOne), MODULUS));
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && incExtra) begin
      value <= stepTwo;
    end else if (inc || incExtra) begin
      value <= stepOne;
    end
  end

endmodule

// File: rtl/version_store.sv
// Versioned circular write buffer feeding the priority router.
// Define VERSION_STORE_OVERWRITE_EN to let writes into a full store evict the oldest slot.
module version_store
  import version_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int VERSION_WIDTH = DEFAULT_VERSION_WIDTH,
  parameter int VERSION_NUM   = DEFAULT_VERSION_NUM
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic                                 writeValid,
  output logic                                 writeReady,
  input  logic [DATA_WIDTH-1:0]                writeData,
  input  logic                                 retire,
  input  logic                                 flush,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  output logic [VERSION_NUM-1:0]               slotValid,
  output logic [VERSION_WIDTH-1:0]             newestVersion,
  output logic [VERSION_WIDTH-1:0]             oldestVersion,
  output logic [$clog2(VERSION_NUM+1)-1:0]     count
);

  localparam int IDX_W = slotIdxWidth(VERSION_NUM);
  localparam int CNT_W = $clog2(VERSION_NUM + 1);

  if (VERSION_NUM < 2 || VERSION_NUM > 2 ** VERSION_WIDTH) begin : gBadConfig
    $error("version_store: VERSION_NUM must lie in [2, 2**VERSION_WIDTH]");
  end

  logic [IDX_W-1:0]         head;
  logic [IDX_W-1:0]         tail;
  logic [VERSION_WIDTH-1:0] nextVersion;
  logic [IDX_W-1:0]         headStepOne;
  logic [IDX_W-1:0]         headStepTwo;
  logic [IDX_W-1:0]         headNext;
  logic [IDX_W-1:0]         retireIdx;
  logic                     full;
  logic                     accept;
  logic                     evict;
  logic                     doRetire;
  logic [CNT_W-1:0]         countNext;

  logic [DATA_WIDTH-1:0]    slotData [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] slotTag  [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    dataNext [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] tagNext  [VERSION_NUM];
  logic [VERSION_NUM-1:0]   validNext;

  // Write handshake: writeData is taken on a rising edge where writeValid && writeReady;
  // writeReady depends only on count and flush, never on writeValid.
  assign full = (count == CNT_W'(VERSION_NUM));
`ifdef VERSION_STORE_OVERWRITE_EN
  assign writeReady = !flush;
  assign evict      = accept && full;
`else
  assign writeReady = !flush && !full;
  assign evict      = 1'b0;
`endif
  assign accept   = writeValid && writeReady;
  assign doRetire = retire && (count != '0) && !flush;

  // An eviction consumes the head slot, so an explicit retire then frees the slot after it.
  assign headStepOne = IDX_W'(wrapNext(int'(head), VERSION_NUM));
  assign headStepTwo = IDX_W'(wrapNext(int'(headStepOne), VERSION_NUM));
  assign retireIdx   = evict ? headStepOne : head;

  always_comb begin
    headNext = head;
    if (flush) begin
      headNext = '0;
    end else if (evict && doRetire) begin
      headNext = headStepTwo;
    end else if (evict || doRetire) begin
      headNext = headStepOne;
    end
  end

  always_comb begin
    countNext = count;
    if (flush) begin
      countNext = '0;
    end else begin
      countNext = count + CNT_W'(accept) - CNT_W'(evict) - CNT_W'(doRetire);
    end
  end

  always_comb begin
    for (int i = 0; i < VERSION_NUM; i++) begin
      dataNext[i]  = slotData[i];
      tagNext[i]   = slotTag[i];
      validNext[i] = slotValid[i];
      if (flush) begin
        dataNext[i]  = '0;
        tagNext[i]   = '0;
        validNext[i] = 1'b0;
      end else begin
        if (doRetire && (IDX_W'(i) == retireIdx)) begin
          dataNext[i]  = '0;
          tagNext[i]   = '0;
          validNext[i] = 1'b0;
        end
        // Applied after the retire clear so an overwrite of the head slot wins.
        if (accept && (IDX_W'(i) == tail)) begin
          dataNext[i]  = writeData;
          tagNext[i]   = nextVersion;
          validNext[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < VERSION_NUM; i++) begin
        slotData[i] <= '0;
        slotTag[i]  <= '0;
      end
      slotValid     <= '0;
      count         <= '0;
      newestVersion <= '0;
      oldestVersion <= '0;
    end else begin
      for (int i = 0; i < VERSION_NUM; i++) begin
        slotData[i] <= dataNext[i];
        slotTag[i]  <= tagNext[i];
      end
      slotValid     <= validNext;
      count         <= countNext;
      oldestVersion <= tagNext[headNext];
      if (accept) begin
        newestVersion <= nextVersion;
      end
    end
  end

  for (genvar i = 0; i < VERSION_NUM; i++) begin : gPack
    assign dataInputs[i*DATA_WIDTH +: DATA_WIDTH]     = slotData[i];
    assign versions[i*VERSION_WIDTH +: VERSION_WIDTH] = slotTag[i];
  end

  wrap_counter #(.MODULUS(VERSION_NUM), .WIDTH(IDX_W)) uHead (
    .clk(clk), .rstN(rstN), .inc(doRetire), .incExtra(evict), .clear(flush), .value(head)
  );

  wrap_counter #(.MODULUS(VERSION_NUM), .WIDTH(IDX_W)) uTail (
    .clk(clk), .rstN(rstN), .inc(accept), .incExtra(1'b0), .clear(flush), .value(tail)
  );

  wrap_counter #(.MODULUS(2 ** VERSION_WIDTH), .WIDTH(VERSION_WIDTH)) uVersion (
    .clk(clk), .rstN(rstN), .inc(accept), .incExtra(1'b0), .clear(1'b0), .value(nextVersion)
  );

endmodule

// File: tb/tb_version_store.sv
// Directed bench for version_store: hand-computed checkpoints plus an in-order queue model.
module tb_version_store;

  localparam int VN = 4;

`ifdef VERSION_STORE_OVERWRITE_EN
  localparam logic [3:0] WRAP_LAST = 4'd6;
`else
  localparam logic [3:0] WRAP_LAST = 4'd5;
`endif

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         writeValid = 1'b0;
  logic         writeReady;
  logic [31:0]  writeData = '0;
  logic         retire = 1'b0;
  logic         flush = 1'b0;
  logic [127:0] dataInputs;
  logic [15:0]  versions;
  logic [3:0]   slotValid;
  logic [3:0]   newestVersion;
  logic [3:0]   oldestVersion;
  logic [2:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: live words oldest-first, with the head slot index they start at
  logic [31:0] exp_q[$];
  logic [3:0]  tag_q[$];
  int          m_head = 0;
  logic [3:0]  m_next_tag = '0;
  logic [3:0]  m_newest = '0;

  version_store dut (
    .clk(clk), .rstN(rstN), .writeValid(writeValid), .writeReady(writeReady),
    .writeData(writeData), .retire(retire), .flush(flush), .dataInputs(dataInputs),
    .versions(versions), .slotValid(slotValid), .newestVersion(newestVersion),
    .oldestVersion(oldestVersion), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_model();
    logic [127:0] e_data;
    logic [15:0]  e_ver;
    logic [3:0]   e_valid;
    e_data  = '0;
    e_ver   = '0;
    e_valid = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      int idx;
      idx = (m_head + i) % VN;
      e_data[idx*32 +: 32] = exp_q[i];
      e_ver[idx*4 +: 4]    = tag_q[i];
      e_valid[idx]         = 1'b1;
    end
    check("dataInputs", dataInputs, e_data);
    check("versions", versions, e_ver);
    check("slotValid", slotValid, e_valid);
    check("count", count, exp_q.size());
    check("oldestVersion", oldestVersion, (tag_q.size() > 0) ? tag_q[0] : 4'd0);
    check("newestVersion", newestVersion, m_newest);
  endtask

  task automatic cycle(input bit wv, input logic [31:0] wd, input bit ret, input bit fl,
                       input bit exp_rdy);
    bit acc;
    writeValid = wv;
    writeData  = wd;
    retire     = ret;
    flush      = fl;
    #1;
    check("writeReady", writeReady, exp_rdy);
    acc = wv && exp_rdy;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      tag_q.delete();
      m_head = 0;
    end else begin
      if (acc && exp_q.size() == VN) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
        m_head = (m_head + 1) % VN;
      end
      if (ret && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
        m_head = (m_head + 1) % VN;
      end
      if (acc) begin
        exp_q.push_back(wd);
        tag_q.push_back(m_next_tag);
        m_newest   = m_next_tag;
        m_next_tag = m_next_tag + 4'd1;
      end
    end
    writeValid = 1'b0;
    retire     = 1'b0;
    flush      = 1'b0;
    compare_model();
  endtask

  task automatic do_reset(input bit wv, input logic [31:0] wd);
    rstN       = 1'b0;
    writeValid = wv;
    writeData  = wd;
    @(posedge clk);
    #1;
    rstN       = 1'b1;
    writeValid = 1'b0;
    exp_q.delete();
    tag_q.delete();
    m_head     = 0;
    m_next_tag = '0;
    m_newest   = '0;
    #1;
    check("reset_writeReady", writeReady, 1'b1);
    check("reset_dataInputs", dataInputs, 128'd0);
    check("reset_versions", versions, 16'h0000);
    compare_model();
  endtask

  initial begin
    do_reset(1'b0, '0);

    // fill the store
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b1);
    check("fill_versions", versions, 16'h3210);
    check("fill_data", dataInputs, 128'h000000a3_000000a2_000000a1_000000a0);
    check("fill_valid", slotValid, 4'b1111);
    check("fill_newest", newestVersion, 4'd3);
    check("fill_oldest", oldestVersion, 4'd0);

`ifndef VERSION_STORE_OVERWRITE_EN
    check("full_writeReady", writeReady, 1'b0);
    // retire frees slot 0 but the write stalls this cycle
    cycle(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0);
    check("stall_count", count, 3'd3);
    check("stall_oldest", oldestVersion, 4'd1);
    check("stall_valid", slotValid, 4'b1110);
    cycle(1'b1, 32'hB0, 1'b0, 1'b0, 1'b1);
    check("b0_versions", versions, 16'h3214);
    check("b0_data", dataInputs[31:0], 32'hB0);
    check("b0_oldest", oldestVersion, 4'd1);
    check("b0_newest", newestVersion, 4'd4);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
`else
    cycle(1'b1, 32'hC4, 1'b0, 1'b0, 1'b1);
    check("ovw_versions", versions, 16'h3214);
    check("ovw_data", dataInputs[31:0], 32'hC4);
    check("ovw_oldest", oldestVersion, 4'd1);
    check("ovw_count", count, 3'd4);
    // overwrite plus explicit retire removes two old words
    cycle(1'b1, 32'hC5, 1'b1, 1'b0, 1'b1);
    check("ovw_ret_versions", versions, 16'h3054);
    check("ovw_ret_count", count, 3'd3);
    check("ovw_ret_oldest", oldestVersion, 4'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
`endif
    check("drained_count", count, 3'd0);
    check("drained_oldest", oldestVersion, 4'd0);

    // retire while empty is ignored
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("empty_retire_count", count, 3'd0);
    check("empty_retire_valid", slotValid, 4'b0000);

    // tag wrap under continuous retire
    for (int i = 0; i < 17; i++) cycle(1'b1, 32'hD0 + i, 1'b1, 1'b0, 1'b1);
    check("wrap_newest", newestVersion, WRAP_LAST);
    check("wrap_oldest", oldestVersion, WRAP_LAST);
    check("wrap_count", count, 3'd1);

    // flush overrides a same-cycle write; version numbering continues
    do_reset(1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE0 + i, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hE3, 1'b0, 1'b1, 1'b0);
    check("flush_valid", slotValid, 4'b0000);
    check("flush_versions", versions, 16'h0000);
    check("flush_newest", newestVersion, 4'd2);
    cycle(1'b1, 32'hE3, 1'b0, 1'b0, 1'b1);
    check("post_flush_versions", versions, 16'h0003);
    check("post_flush_data", dataInputs[31:0], 32'hE3);
    check("post_flush_valid", slotValid, 4'b0001);

    // reset in mid-stream with a write pending
    cycle(1'b1, 32'hF0, 1'b0, 1'b0, 1'b1);
    do_reset(1'b1, 32'hF1);
    check("midreset_newest", newestVersion, 4'd0);
    check("midreset_count", count, 3'd0);
    cycle(1'b1, 32'hF2, 1'b0, 1'b0, 1'b1);
    check("after_reset_versions", versions, 16'h0000);
    check("after_reset_data", dataInputs[31:0], 32'hF2);
    check("after_reset_valid", slotValid, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/version_store.md
# version_store

Versioned write buffer directly upstream of the priority router. It accepts a stream of data words and stamps each accepted word with a monotonically increasing, wrapping version number. It keeps the newest VERSION_NUM words in a circular slot array and drives the flattened `versions` / `dataInputs` buses that the router consumes. The consumer signals explicit retirement of the oldest version, which frees slots.

## Interface
- DATA_WIDTH, 32, width of one data word
- VERSION_WIDTH, 4, width of one version tag
- VERSION_NUM, 4, number of slots; must satisfy 2 ≤ VERSION_NUM ≤ 2**VERSION_WIDTH (elaboration error otherwise)

- clk  in  1  single clock, rising edge
- rstN  in  1  synchronous, active-low reset
- writeValid  in  1  writeData present
- writeReady  out  1  store can accept a write this cycle
- writeData  in  DATA_WIDTH  word to store
- retire  in  1  free the oldest valid slot
- flush  in  1  invalidate all slots
- dataInputs  out  DATA_WIDTH*VERSION_NUM  slot i data at [i*DATA_WIDTH +: DATA_WIDTH]
- versions  out  VERSION_WIDTH*VERSION_NUM  slot i tag at [i*VERSION_WIDTH +: VERSION_WIDTH]
- slotValid  out  VERSION_NUM  bit i set when slot i holds a live word
- newestVersion  out  VERSION_WIDTH  tag of the most recently accepted write
- oldestVersion  out  VERSION_WIDTH  tag in the head slot (0 when empty)
- count  out  $clog2(VERSION_NUM+1)  number of live slots

## Operation
- State: head pointer, tail pointer, count, nextVersion counter, and the slot data, tag and valid arrays.
- Write accepted when writeValid && writeReady:
  - slot[tail] ← {writeData, nextVersion}, valid set;
  - tail advances mod VERSION_NUM;
  - newestVersion ← nextVersion;
  - nextVersion increments mod 2**VERSION_WIDTH (wraps 1111→0000).
- Retire when retire && count>0:
  - slot[head] valid cleared; its data and tag are zeroed;
  - head advances.
- Retire when empty is ignored.
- writeReady = !flush && (count < VERSION_NUM), unless the overwrite feature is compiled in (see Configuration).
- Write and retire in the same cycle, non-empty and non-full: both happen and count is unchanged.
- When full, writeReady is low. A same-cycle retire frees a slot, and the write is accepted no earlier than the next cycle.
- flush:
  - clears all valid bits, zeroes data and tags, and resets head, tail and count to 0;
  - nextVersion and newestVersion are retained, so versions stay unique across a flush;
  - flush overrides write and retire in the same cycle.
- Priority: rstN low > flush > retire/write.
- Live tags are always distinct because VERSION_NUM ≤ 2**VERSION_WIDTH.

## Timing
- All state updates happen on the rising clk edge. Every output is registered except writeReady, which is a combinational function of count and flush.
- Latency: a write accepted at edge N is visible on dataInputs, versions and slotValid after edge N.
- Retire latency: 1 cycle.
- Reset (rstN low at an edge), also mid-operation:
  - dataInputs=0, versions=0, slotValid=0, count=0;
  - newestVersion=0, oldestVersion=0, nextVersion=0;
  - head=tail=0;
  - writeReady=1 from the first cycle after reset.
- Handshake: writeData is sampled only when writeValid && writeReady. The producer holds writeData while writeValid is high and writeReady is low.

## Configuration
- VERSION_STORE_OVERWRITE_EN defined:
  - writeReady = !flush;
  - a write into a full store evicts the head slot in the same cycle (implicit retire) and count stays VERSION_NUM;
  - an explicit retire in the same cycle as an overwrite retires one additional slot, so count becomes VERSION_NUM−1.
- Not defined: full store backpressures via writeReady as described above.

## Structure
- Shared package `version_pkg`:
  - default DATA_WIDTH, VERSION_WIDTH and VERSION_NUM constants;
  - slot index width function (clog2 of VERSION_NUM);
  - slot record typedef {data, version, valid}.
- One sub-module, `wrap_counter`: parameterised modulus, synchronous active-low reset, increment and clear inputs. It is instantiated for head, tail and nextVersion.

## Test plan
- Reset, then 4 writes of 0xA0..0xA3 → slots 0..3 hold tags 0..3, slotValid=1111, writeReady=0, newestVersion=3, oldestVersion=0.
- Full store, writeValid with 0xB0 and retire together → slot 0 freed and the write stalls. Next cycle 0xB0 lands in slot 0 with tag 4, oldestVersion=1.
- Write 17 words with continuous retire → tags wrap 15→0, and live tags stay unique and contiguous mod 16.
- Retire while empty → no change, count=0.
- flush with writeValid high, after tags 0..2 are written → all slots invalid, write not accepted. The next write gets tag 3 in slot 0.
- With VERSION_STORE_OVERWRITE_EN, a 5th write 0xC4 into a full store → slot 0 overwritten with tag 4, oldestVersion=1, count=4. rstN low mid-stream → every output returns to 0 one cycle later.
